// File: rtl/keyboard_pkg.sv
// Shared constants and types for the keyboard port controller.
//   - processor port IDs for status / data / flags+command
//   - PS/2 prefix bytes (extended, break)
//   - prefix FSM state encoding
//   - FIFO entry width and command bit positions
package keyboard_pkg;

    localparam logic [7:0] KB_PORT_STATUS = 8'h05;
    localparam logic [7:0] KB_PORT_DATA   = 8'h06;
    localparam logic [7:0] KB_PORT_FLAGS  = 8'h07;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    // Entry layout: {ext, brk, code[7:0]}
    localparam int ENTRY_W = 10;

    localparam int CMD_FLUSH   = 0;
    localparam int CMD_CLR_OVF = 1;
    localparam int CMD_INT_EN  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } pfx_state_e;

endpackage

// File: rtl/keyboard_port_ctrl_scan_fifo.sv
// scan_fifo: synchronous FIFO, power-of-2 depth (2..16), first-word-fall-through
// read port (dout is the current head).
//   clk, reset (sync, active-low)
//   push/din   : write an entry; accepted when not full, or when full with a pop
//   pop        : remove head; ignored when empty
//   flush      : empty the FIFO; overrides push and pop
//   dout       : head entry (undefined when empty)
//   count[4:0] : occupancy 0..DEPTH; full / empty flags
module scan_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [4:0]       count,
    output logic             full,
    output logic             empty
);
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]       count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == 5'd0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A pop frees the head slot this cycle, so a push into a full FIFO is
    // legal when paired with one (write slot == read slot in that case).
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = 5'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop)
                rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop)
                count_d = count_q + 5'd1;
            else if (do_pop && !do_push)
                count_d = count_q - 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 5'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed through count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/keyboard_port_ctrl.sv
// keyboard_port_ctrl: folds PS/2 E0/F0 prefixes into per-key flags, queues
// decoded keys, and serves processor port reads/writes.
//   clk, reset (sync, active-low)
//   scan_code/scan_valid : bytes from the PS/2 receiver
//   Port_ID, Read_Strobe, Write_Strobe, Out_Port : processor I/O cycle
//   In_Port   : registered read data for Port_ID (1-cycle latency)
//   interrupt : registered level, int_en && FIFO not empty
module keyboard_port_ctrl
    import keyboard_pkg::*;
#(
    parameter int         DEPTH       = 16,
    parameter logic [7:0] PORT_STATUS = KB_PORT_STATUS,
    parameter logic [7:0] PORT_DATA   = KB_PORT_DATA,
    parameter logic [7:0] PORT_FLAGS  = KB_PORT_FLAGS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    input  logic [7:0] Port_ID,
    input  logic       Read_Strobe,
    input  logic       Write_Strobe,
    input  logic [7:0] Out_Port,
    output logic [7:0] In_Port,
    output logic       interrupt
);
    pfx_state_e         state_q, state_d;
    logic               overflow_q, overflow_d;
    logic               int_en_q, int_en_d;
    logic [7:0]         in_port_q, in_port_d;
    logic               interrupt_q, interrupt_d;

    logic               push, pop, flush, wr_cmd;
    logic [ENTRY_W-1:0] push_entry, head;
    logic [4:0]         count;
    logic               full, empty, not_empty;

    assign not_empty = !empty;
    assign wr_cmd    = Write_Strobe && (Port_ID == PORT_FLAGS);
    assign flush     = wr_cmd && Out_Port[CMD_FLUSH];
    assign pop       = Read_Strobe && (Port_ID == PORT_DATA) && not_empty;

    scan_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (push_entry),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Prefix FSM: prefixes only steer state; every non-prefix byte (and any
    // byte after F0) emits one entry and returns to IDLE, even if dropped.
    always_comb begin
        state_d    = state_q;
        push       = 1'b0;
        push_entry = '0;
        if (scan_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (scan_code == SC_EXT)      state_d = ST_EXT;
                    else if (scan_code == SC_BRK) state_d = ST_BRK;
                    else begin
                        push       = 1'b1;
                        push_entry = {2'b00, scan_code};
                    end
                end
                ST_EXT: begin
                    if (scan_code == SC_BRK)      state_d = ST_EXT_BRK;
                    else if (scan_code != SC_EXT) begin
                        push       = 1'b1;
                        push_entry = {2'b10, scan_code};
                        state_d    = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    push       = 1'b1;
                    push_entry = {2'b01, scan_code};
                    state_d    = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    push       = 1'b1;
                    push_entry = {2'b11, scan_code};
                    state_d    = ST_IDLE;
                end
            endcase
        end
        if (flush)
            state_d = ST_IDLE;
    end

    always_comb begin
        overflow_d = overflow_q;
        int_en_d   = int_en_q;
        if (wr_cmd) begin
            int_en_d = Out_Port[CMD_INT_EN];
            if (Out_Port[CMD_CLR_OVF])
                overflow_d = 1'b0;
        end
        // A drop in the same cycle as a clear still leaves overflow set.
        if (push && full && !pop && !flush)
            overflow_d = 1'b1;
    end

    always_comb begin
        in_port_d = 8'h00;
        if (Port_ID == PORT_STATUS)
            in_port_d = {not_empty, overflow_q, full, count};
        else if (Port_ID == PORT_DATA)
            in_port_d = not_empty ? head[7:0] : 8'h00;
        else if (Port_ID == PORT_FLAGS)
            in_port_d = {5'b0, int_en_q, head[9] & not_empty, head[8] & not_empty};
        interrupt_d = int_en_q && not_empty;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            overflow_q  <= 1'b0;
            int_en_q    <= 1'b0;
            in_port_q   <= 8'h00;
            interrupt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            overflow_q  <= overflow_d;
            int_en_q    <= int_en_d;
            in_port_q   <= in_port_d;
            interrupt_q <= interrupt_d;
        end
    end

    assign In_Port   = in_port_q;
    assign interrupt = interrupt_q;

endmodule

// File: tb/tb_keyboard_port_ctrl.sv
module tb_keyboard_port_ctrl;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       scan_valid = 1'b0;
    logic [7:0] Port_ID = 8'h00;
    logic       Read_Strobe = 1'b0;
    logic       Write_Strobe = 1'b0;
    logic [7:0] Out_Port = 8'h00;
    logic [7:0] In_Port;
    logic       interrupt;

    keyboard_port_ctrl #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .scan_code    (scan_code),
        .scan_valid   (scan_valid),
        .Port_ID      (Port_ID),
        .Read_Strobe  (Read_Strobe),
        .Write_Strobe (Write_Strobe),
        .Out_Port     (Out_Port),
        .In_Port      (In_Port),
        .interrupt    (interrupt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of {ext,brk,code}, pending-prefix flags.
    logic [9:0] mq[$];
    bit m_ext, m_brk, m_ovf, m_ien;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [7:0] pid);
        int n = mq.size();
        logic ne = (n != 0);
        case (pid)
            8'h05:   return {ne, m_ovf, n == DEPTH, 5'(n)};
            8'h06:   return ne ? mq[0][7:0] : 8'h00;
            8'h07:   return {5'b0, m_ien, ne ? mq[0][9] : 1'b0, ne ? mq[0][8] : 1'b0};
            default: return 8'h00;
        endcase
    endfunction

    // One clock cycle: drive, predict registered outputs, check, advance model.
    task automatic step(input logic rst_n, input logic sv, input logic [7:0] code,
                        input logic [7:0] pid, input logic rs, input logic ws,
                        input logic [7:0] op);
        logic [7:0] e_in;
        logic       e_int;
        bit         fl, pp, do_push, was_full;
        logic [9:0] ent;
        @(negedge clk);
        reset = rst_n; scan_valid = sv; scan_code = code; Port_ID = pid;
        Read_Strobe = rs; Write_Strobe = ws; Out_Port = op;
        if (!rst_n) begin
            e_in = 8'h00; e_int = 1'b0;
        end else begin
            e_in = m_read(pid); e_int = m_ien && (mq.size() != 0);
        end
        @(posedge clk);
        #1;
        chk("in_port", {8'h00, In_Port}, {8'h00, e_in});
        chk("interrupt", {15'h0, interrupt}, {15'h0, e_int});
        if (!rst_n) begin
            mq.delete(); m_ext = 0; m_brk = 0; m_ovf = 0; m_ien = 0;
        end else begin
            fl = ws && pid == 8'h07 && op[0];
            pp = rs && pid == 8'h06 && mq.size() != 0;
            do_push = 0; ent = '0;
            if (sv) begin
                if (m_brk) begin
                    ent = {m_ext, 1'b1, code}; do_push = 1; m_ext = 0; m_brk = 0;
                end else if (code == 8'hE0) m_ext = 1;
                else if (code == 8'hF0) m_brk = 1;
                else begin
                    ent = {m_ext, 1'b0, code}; do_push = 1; m_ext = 0;
                end
            end
            if (ws && pid == 8'h07) begin
                if (op[1]) m_ovf = 0;
                m_ien = op[2];
            end
            if (fl) begin
                mq.delete(); m_ext = 0; m_brk = 0;
            end else begin
                was_full = (mq.size() == DEPTH);
                if (pp) void'(mq.pop_front());
                if (do_push) begin
                    if (was_full && !pp) m_ovf = 1;
                    else mq.push_back(ent);
                end
            end
        end
    endtask

    task automatic idle(input logic [7:0] pid); step(1, 0, 8'h00, pid, 0, 0, 8'h00); endtask
    task automatic send(input logic [7:0] b);   step(1, 1, b, 8'h05, 0, 0, 8'h00);   endtask
    task automatic popd();                      step(1, 0, 8'h00, 8'h06, 1, 0, 8'h00); endtask
    task automatic wrcmd(input logic [7:0] op); step(1, 0, 8'h00, 8'h07, 0, 1, op);   endtask

    logic [7:0] stream [8] = '{8'h1C, 8'hE0, 8'h75, 8'hF0, 8'h1C, 8'hE0, 8'hF0, 8'h75};
    logic [7:0] flg    [4] = '{8'h00, 8'h02, 8'h01, 8'h03};
    logic [7:0] codes  [4] = '{8'h1C, 8'h75, 8'h1C, 8'h75};

    initial begin
        // Reset and empty status
        repeat (3) step(0, 0, 8'h00, 8'h05, 0, 0, 8'h00);
        idle(8'h05);
        chk("rst_status", {8'h0, In_Port}, 16'h0000);
        chk("rst_irq", {15'h0, interrupt}, 16'h0000);

        // Prefix folding
        foreach (stream[i]) send(stream[i]);
        idle(8'h05);
        chk("status4", {8'h0, In_Port}, 16'h0084);
        for (int i = 0; i < 4; i++) begin
            idle(8'h07);
            chk("flags", {8'h0, In_Port}, {8'h0, flg[i]});
            popd();
            chk("code", {8'h0, In_Port}, {8'h0, codes[i]});
        end

        // Interrupt rise/fall
        wrcmd(8'h04);
        send(8'h2A);
        chk("irq_lag", {15'h0, interrupt}, 16'h0000);
        idle(8'h05);
        chk("irq_rise", {15'h0, interrupt}, 16'h0001);
        popd();
        idle(8'h05);
        chk("irq_fall", {15'h0, interrupt}, 16'h0000);
        wrcmd(8'h00);

        // Overflow
        for (int i = 0; i < 17; i++) send(8'h10 + 8'(i));
        idle(8'h05);
        chk("ovf_status", {8'h0, In_Port}, 16'h00F0);
        wrcmd(8'h02);
        idle(8'h05);
        chk("ovf_clr", {8'h0, In_Port}, 16'h00B0);

        // Full with simultaneous push and pop
        step(1, 1, 8'h99, 8'h06, 1, 0, 8'h00);
        idle(8'h05);
        chk("full_pp", {8'h0, In_Port}, 16'h00B0);
        for (int i = 0; i < DEPTH; i++) popd();
        chk("full_last", {8'h0, In_Port}, 16'h0099);

        // Flush resets prefix FSM
        send(8'hE0);
        wrcmd(8'h01);
        send(8'h1C);
        idle(8'h07);
        chk("flush_flags", {8'h0, In_Port}, 16'h0000);
        idle(8'h05);
        chk("flush_status", {8'h0, In_Port}, 16'h0081);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic       r_rst, r_sv, r_rs, r_ws;
            logic [7:0] r_code, r_pid, r_op;
            int         sel;
            r_rst = ($urandom_range(0, 199) != 0);
            r_sv  = ($urandom_range(0, 2) == 0);
            sel   = $urandom_range(0, 5);
            r_code = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom);
            sel   = $urandom_range(0, 7);
            r_pid = (sel < 3) ? 8'h05 : (sel < 6) ? 8'h06 : (sel == 6) ? 8'h07 : 8'($urandom);
            // Alternate pop-heavy and pop-light phases so the FIFO fills and drains.
            r_rs  = ((i / 400) % 2 == 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) == 0);
            r_ws  = ($urandom_range(0, 15) == 0);
            r_op  = 8'($urandom);
            r_op[0] = ($urandom_range(0, 5) == 0);
            step(r_rst, r_sv, r_code, r_pid, r_rs, r_ws, r_op);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keyboard_port_ctrl.md
# keyboard_port_ctrl

Processor-side controller for the keyboard path: takes raw scan bytes from the PS/2 receiver, folds E0/F0 prefixes into per-key flags with a small FSM, and buffers decoded keys in a FIFO. It answers the controller's INPUT/OUTPUT cycles on ports 0x05–0x07: status, data with pop-on-read, and head flags/command. It sits between the PS/2 receiver and the processor's In_Port/Out_Port buses, and replaces ad-hoc port selection for keyboard data.

## Interface
- DEPTH, 16: FIFO entries; power of 2, range 2..16.
- PORT_STATUS, 8'h05: status port ID.
- PORT_DATA, 8'h06: key-code port ID; a read of this port pops the FIFO.
- PORT_FLAGS, 8'h07: read returns head flags; write is the command register.

- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-low (reset==0 resets on the clk edge).
- scan_code  in  8  byte from PS/2 receiver.
- scan_valid  in  1  one-cycle strobe; scan_code is valid.
- Port_ID  in  8  processor port address.
- Read_Strobe  in  1  processor read strobe.
- Write_Strobe  in  1  processor write strobe.
- Out_Port  in  8  processor write data.
- In_Port  out  8  registered read data; reset 8'h00.
- interrupt  out  1  registered, level; reset 0.

## Operation
- FIFO entry: 10 bits {ext, brk, code[7:0]}. Prefix bytes are never stored.
- Prefix FSM, with states IDLE, EXT, BRK and EXT_BRK, advances only on scan_valid:
  - IDLE: E0→EXT; F0→BRK; any other byte pushes {0,0,b} and stays in IDLE.
  - EXT: F0→EXT_BRK; E0 stays in EXT; any other byte pushes {1,0,b}→IDLE.
  - BRK: any byte, including E0/F0, pushes {0,1,b}→IDLE.
  - EXT_BRK: any byte pushes {1,1,b}→IDLE.
- Read mux, sampled from Port_ID every cycle:
  - PORT_STATUS → {not_empty, overflow, full, count[4:0]}.
  - PORT_DATA → head code; 8'h00 if empty.
  - PORT_FLAGS → {5'b0, int_en, ext, brk} of head; ext/brk read 0 if empty.
  - Any other ID → 8'h00.
- Pop: Read_Strobe && Port_ID==PORT_DATA && not_empty. Pop on empty is ignored.
- Command: Write_Strobe && Port_ID==PORT_FLAGS, decoded from Out_Port:
  - bit0=1: flush FIFO (count=0, pointers=0) and force FSM to IDLE.
  - bit1=1: clear overflow.
  - bit2: loaded into int_en.
- Push when full, with no pop in the same cycle: byte dropped, overflow set sticky. The FSM still returns to IDLE.
- Push and pop in the same cycle: both happen and count is unchanged. This includes the full case, where the push is accepted.
- Flush and push in the same cycle: flush wins and the byte is discarded. Flush also overrides a pop.
- Counter and pointer arithmetic: pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is 5 bits and range 0..DEPTH. full = (count==DEPTH); not_empty = (count!=0).
- Reset: FIFO empty, FSM IDLE, overflow=0, int_en=0, In_Port=0, interrupt=0.

## Timing
- In_Port = mux(Port_ID, state) registered on each clk edge, so there is 1 cycle of latency from Port_ID. This is valid for the processor's two-cycle INPUT, where Read_Strobe arrives in the second cycle.
- Pop takes effect on the edge at the end of the Read_Strobe cycle. The next head is visible on In_Port two cycles after that strobe, provided Port_ID is held.
- Push: the entry is written on the scan_valid edge. not_empty and count reflect it in the following cycle, and In_Port reflects it one cycle later still.
- interrupt = registered (int_en && not_empty). It rises 2 cycles after the first push and falls 2 cycles after the pop that empties the FIFO or a flush.
- Reset is honoured on any edge mid-operation and overrides all strobes in that cycle.

## Structure
- Package keyboard_pkg holds:
  - port IDs 8'h05/06/07;
  - prefix constants 8'hE0 (extended) and 8'hF0 (break);
  - FSM state enum;
  - entry width 10;
  - command bit positions.
- Sub-module scan_fifo: synchronous FIFO with parameterised depth and width. Ports: push, pop, flush, din, dout, count, full, empty. Same clk/reset.
- Top level: prefix FSM, port decode/read mux, command register, interrupt.

## Test plan
- Reset, then read 0x05 → In_Port 8'h00; interrupt 0.
- Stream 1C, E0 75, F0 1C, E0 F0 75:
  - four entries are stored; 0x05 reads 8'h84;
  - popping 0x06 ×4 yields 1C/75/1C/75;
  - the preceding 0x07 reads give flags 00/02/01/03.
- Write 0x07=8'h04, then push 1 byte → interrupt rises 2 cycles later. Pop it → interrupt falls 2 cycles after Read_Strobe.
- Push 17 non-prefix bytes with DEPTH=16:
  - 0x05 reads 8'hF0 (not_empty, overflow, full, count=16);
  - the 17th byte is lost;
  - write 0x07=8'h02 → 0x05 reads 8'hB0.
- Full FIFO, with scan_valid and a 0x06 pop in the same cycle → count stays 16, overflow stays 0, and the new byte appears last.
- Send E0, then write 0x07=8'h01, then send 1C → the entry is {0,0,1C} (FSM reset by flush); 0x05 reads 8'h81.
